reg_bank_ctrl: RTL

- Command sequencer that sits directly upstream of the register bank and drives its write port (we, addr_rd, data_in) and read addresses (addr_rs1, addr_rs2).
- It captures the returned rs1/rs2 values and presents them on a valid/ready response port.
- Accepts single commands on a valid/ready interface: single write, dual read, or bulk fill of every register with an LFSR sequence.
- Runs in the same clock domain as the bank.

---
 rtl/reg_bank_ctrl_if.sv | 47 ++++
 rtl/reg_bank_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank_ctrl_if
//  Purpose  : Command, register-bank and response signals of reg_bank_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface reg_bank_ctrl_if #(
    parameter int W = 7,
    parameter int N = 4
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [N-1:0] cmd_addr_a;
    logic [N-1:0] cmd_addr_b;
    logic [W-1:0] cmd_data;

    logic         we;
    logic [N-1:0] addr_rd;
    logic [W-1:0] data_out;
    logic [N-1:0] addr_rs1;
    logic [N-1:0] addr_rs2;
    logic [W-1:0] rs1_in;
    logic [W-1:0] rs2_in;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_rs1;
    logic [W-1:0] rsp_rs2;
    logic         fill_done;
    logic         err;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data,
        input  rs1_in, rs2_in, rsp_ready,
        output cmd_ready, we, addr_rd, data_out, addr_rs1, addr_rs2,
        output rsp_valid, rsp_rs1, rsp_rs2, fill_done, err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data,
        output rs1_in, rs2_in, rsp_ready,
        input  cmd_ready, we, addr_rd, data_out, addr_rs1, addr_rs2,
        input  rsp_valid, rsp_rs1, rsp_rs2, fill_done, err
    );
endinterface
`default_nettype wire

// File: rtl/reg_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank_ctrl
//  Purpose  : Command sequencer driving a register bank: write, dual read,
//             and LFSR bulk fill, with a valid/ready response port.
//  Revision : 1.0  initial release
// ============================================================================
module reg_bank_ctrl #(
    parameter int           W      = 7,
    parameter int           N      = 4,
    parameter int           RD_LAT = 0,
    parameter logic [W-1:0] SEED   = 'h01,
    parameter logic [W-1:0] TAPS   = 'h60
) (
    input  wire logic      clk,
    input  wire logic      reset,
    reg_bank_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_READ    = 3'd2,
        S_RD_WAIT = 3'd3,
        S_FILL    = 3'd4
    } state_t;

    localparam logic [1:0]   c_op_write = 2'b00;
    localparam logic [1:0]   c_op_read  = 2'b01;
    localparam logic [1:0]   c_op_fill  = 2'b10;
    localparam logic [N-1:0] c_addr_one = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] c_addr_max = {N{1'b1}};

    state_t       r_state,     w_state_nxt;
    logic         r_we,        w_we_nxt;
    logic [N-1:0] r_addr_rd,   w_addr_rd_nxt;
    logic [W-1:0] r_data_out,  w_data_out_nxt;
    logic [N-1:0] r_addr_rs1,  w_addr_rs1_nxt;
    logic [N-1:0] r_addr_rs2,  w_addr_rs2_nxt;
    logic         r_rsp_valid, w_rsp_valid_nxt;
    logic [W-1:0] r_rsp_rs1,   w_rsp_rs1_nxt;
    logic [W-1:0] r_rsp_rs2,   w_rsp_rs2_nxt;
    logic         r_fill_done, w_fill_done_nxt;
    logic         r_err,       w_err_nxt;
    logic [W-1:0] r_lfsr,      w_lfsr_nxt;

    logic         w_cmd_ready;
    logic         w_accept;
    logic         w_rd_wait;
    logic [W-1:0] w_lfsr_step;

    // A registered-output bank needs one extra cycle before the read data is valid
    generate
        if (RD_LAT == 1) begin : g_rd_wait
            assign w_rd_wait = 1'b1;
        end else begin : g_rd_direct
            assign w_rd_wait = 1'b0;
        end
    endgenerate

    assign w_cmd_ready = (r_state == S_IDLE) && !r_rsp_valid;
    assign w_accept    = bus.cmd_valid && w_cmd_ready;
    assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

    always_comb begin
        w_state_nxt     = r_state;
        w_we_nxt        = 1'b0;
        w_addr_rd_nxt   = r_addr_rd;
        w_data_out_nxt  = r_data_out;
        w_addr_rs1_nxt  = r_addr_rs1;
        w_addr_rs2_nxt  = r_addr_rs2;
        w_rsp_valid_nxt = r_rsp_valid && !bus.rsp_ready;
        w_rsp_rs1_nxt   = r_rsp_rs1;
        w_rsp_rs2_nxt   = r_rsp_rs2;
        w_fill_done_nxt = 1'b0;
        w_err_nxt       = 1'b0;
        w_lfsr_nxt      = r_lfsr;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (bus.cmd_op)
                        c_op_write: begin
                            w_we_nxt       = 1'b1;
                            w_addr_rd_nxt  = bus.cmd_addr_a;
                            w_data_out_nxt = bus.cmd_data;
                            w_state_nxt    = S_WRITE;
                        end
                        c_op_read: begin
                            w_addr_rs1_nxt = bus.cmd_addr_a;
                            w_addr_rs2_nxt = bus.cmd_addr_b;
                            w_state_nxt    = S_READ;
                        end
                        c_op_fill: begin
                            w_we_nxt       = 1'b1;
                            w_addr_rd_nxt  = '0;
                            w_data_out_nxt = SEED;
                            w_lfsr_nxt     = SEED;
                            w_state_nxt    = S_FILL;
                        end
                        default: begin
                            w_err_nxt = 1'b1;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                w_state_nxt = S_IDLE;
            end
            S_READ: begin
                if (w_rd_wait) begin
                    w_state_nxt = S_RD_WAIT;
                end else begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rs1_nxt   = bus.rs1_in;
                    w_rsp_rs2_nxt   = bus.rs2_in;
                    w_state_nxt     = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_rs1_nxt   = bus.rs1_in;
                w_rsp_rs2_nxt   = bus.rs2_in;
                w_state_nxt     = S_IDLE;
            end
            S_FILL: begin
                // r_lfsr always mirrors the value currently on data_out
                w_lfsr_nxt = w_lfsr_step;
                if (r_addr_rd == c_addr_max) begin
                    w_fill_done_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_we_nxt       = 1'b1;
                    w_addr_rd_nxt  = r_addr_rd + c_addr_one;
                    w_data_out_nxt = w_lfsr_step;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_addr_rd   <= '0;
            r_data_out  <= '0;
            r_addr_rs1  <= '0;
            r_addr_rs2  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rs1   <= '0;
            r_rsp_rs2   <= '0;
            r_fill_done <= 1'b0;
            r_err       <= 1'b0;
            r_lfsr      <= SEED;
        end else begin
            r_state     <= w_state_nxt;
            r_we        <= w_we_nxt;
            r_addr_rd   <= w_addr_rd_nxt;
            r_data_out  <= w_data_out_nxt;
            r_addr_rs1  <= w_addr_rs1_nxt;
            r_addr_rs2  <= w_addr_rs2_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rs1   <= w_rsp_rs1_nxt;
            r_rsp_rs2   <= w_rsp_rs2_nxt;
            r_fill_done <= w_fill_done_nxt;
            r_err       <= w_err_nxt;
            r_lfsr      <= w_lfsr_nxt;
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.we        = r_we;
    assign bus.addr_rd   = r_addr_rd;
    assign bus.data_out  = r_data_out;
    assign bus.addr_rs1  = r_addr_rs1;
    assign bus.addr_rs2  = r_addr_rs2;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rs1   = r_rsp_rs1;
    assign bus.rsp_rs2   = r_rsp_rs2;
    assign bus.fill_done = r_fill_done;
    assign bus.err       = r_err;

endmodule
`default_nettype wire
